// File: rtl/image_params_pkg.sv
// Frame-buffer geometry shared by the capture (image_writer) and VGA readout paths.
package image_params;
  localparam int WIDTH_ADDR  = 16;
  localparam int WIDTH_COLOR = 4;
  localparam int WIDTH_POS   = 10;
  localparam int WIDTH_IMG   = 200;
  localparam int HEIGHT_IMG  = 200;
endpackage

// File: rtl/image_writer_addr_gen.sv
// Raster position tracker: x, y and row_base, with address = row_base + x (no multiplier).
module img_addr_gen
  import image_params::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_adv_pixel,
  input  logic                  i_adv_line,
  output logic [WIDTH_ADDR-1:0] o_address,
  output logic                  o_x_last,
  output logic                  o_x_full,
  output logic                  o_line_last
);
  localparam logic [WIDTH_POS-1:0]  X_END    = WIDTH_POS'(WIDTH_IMG);
  localparam logic [WIDTH_POS-1:0]  Y_LAST   = WIDTH_POS'(HEIGHT_IMG - 1);
  localparam logic [WIDTH_ADDR-1:0] ROW_STEP = WIDTH_ADDR'(WIDTH_IMG);

  logic [WIDTH_POS-1:0]  r_x, r_y;
  logic [WIDTH_ADDR-1:0] r_row_base;
  logic [WIDTH_POS-1:0]  w_x_base, w_y_base;
  logic [WIDTH_ADDR-1:0] w_rb_base;

  // Clear and advance may coincide (sof beat): advances apply on top of the cleared position.
  always_comb begin
    w_x_base  = i_clear ? '0 : r_x;
    w_y_base  = i_clear ? '0 : r_y;
    w_rb_base = i_clear ? '0 : r_row_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x        <= '0;
      r_y        <= '0;
      r_row_base <= '0;
    end else if (i_adv_line) begin
      r_x        <= '0;
      r_y        <= w_y_base + 1'b1;
      r_row_base <= w_rb_base + ROW_STEP;
    end else if (i_adv_pixel) begin
      r_x        <= (w_x_base == X_END) ? w_x_base : w_x_base + 1'b1;
      r_y        <= w_y_base;
      r_row_base <= w_rb_base;
    end else begin
      r_x        <= w_x_base;
      r_y        <= w_y_base;
      r_row_base <= w_rb_base;
    end
  end

  assign o_address   = r_row_base + {{(WIDTH_ADDR - WIDTH_POS){1'b0}}, r_x};
  assign o_x_last    = (r_x == X_END - 1'b1);
  assign o_x_full    = (r_x == X_END);
  assign o_line_last = (r_y == Y_LAST);
endmodule

// File: rtl/image_writer.sv
// Captures one framed pixel stream per start pulse into the frame buffer write port,
// flagging bad line lengths and unexpected start-of-frame markers.
module image_writer
  import image_params::*;
(
  input  logic                   pixel_clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH_COLOR-1:0] s_data,
  input  logic                   s_sof,
  input  logic                   s_eol,
  output logic [WIDTH_ADDR-1:0]  address,
  output logic [WIDTH_COLOR-1:0] dout,
  output logic                   en_write,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_line,
  output logic                   err_frame
);
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SOF, ST_WRITE, ST_DONE} state_t;

  state_t                   r_state;
  logic [WIDTH_ADDR-1:0]    r_address;
  logic [WIDTH_COLOR-1:0]   r_dout;
  logic                     r_en_write, r_busy, r_frame_done, r_err_line, r_err_frame;
  logic                     w_accept, w_in_frame, w_clear, w_adv_pixel, w_adv_line;
  logic                     w_line_err, w_frame_end, w_x_last, w_x_full, w_line_last;
  logic [WIDTH_ADDR-1:0]    w_address, w_wr_addr;

  // Handshake: a beat transfers on a cycle where s_valid & s_ready; s_ready depends only on
  // the state register, never on s_valid. Only transferred beats sample s_data/s_sof/s_eol.
  assign s_ready     = (r_state == ST_WAIT_SOF) || (r_state == ST_WRITE);
  assign w_accept    = s_valid & s_ready;
  assign w_in_frame  = w_accept & (s_sof | (r_state == ST_WRITE));
  assign w_clear     = ((r_state == ST_IDLE) & start) | (w_accept & s_sof);
  assign w_adv_pixel = w_in_frame & (s_sof | ~w_x_full);
  assign w_adv_line  = w_in_frame & s_eol;
  assign w_wr_addr   = s_sof ? '0 : w_address;
  assign w_line_err  = w_adv_line & (s_sof | ~w_x_last);
  assign w_frame_end = w_adv_line & ~s_sof & w_line_last;

  img_addr_gen u_addr_gen (
    .clk         (pixel_clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_adv_pixel (w_adv_pixel),
    .i_adv_line  (w_adv_line),
    .o_address   (w_address),
    .o_x_last    (w_x_last),
    .o_x_full    (w_x_full),
    .o_line_last (w_line_last)
  );

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_address    <= '0;
      r_dout       <= '0;
      r_en_write   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_line   <= 1'b0;
      r_err_frame  <= 1'b0;
    end else begin
      r_en_write   <= w_adv_pixel;
      r_frame_done <= 1'b0;
      if (w_adv_pixel) begin
        r_address <= w_wr_addr;
        r_dout    <= s_data;
      end
      if (w_line_err) r_err_line <= 1'b1;
      if (w_in_frame & s_sof & (r_state == ST_WRITE)) r_err_frame <= 1'b1;
      case (r_state)
        ST_IDLE: if (start) begin
          r_state     <= ST_WAIT_SOF;
          r_busy      <= 1'b1;
          r_err_line  <= 1'b0;
          r_err_frame <= 1'b0;
        end
        ST_WAIT_SOF: if (w_in_frame) r_state <= ST_WRITE;
        ST_WRITE: if (w_frame_end) begin
          r_state      <= ST_DONE;
          r_frame_done <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign address    = r_address;
  assign dout       = r_dout;
  assign en_write   = r_en_write;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign err_line   = r_err_line;
  assign err_frame  = r_err_frame;
endmodule

// File: tb/tb_image_writer.sv
// Bench for image_writer: directed frames drive a write scoreboard checked by a separate monitor.
module tb_image_writer;
  import image_params::*;

  localparam int W = 1 + WIDTH_ADDR + WIDTH_COLOR;

  logic                   pixel_clk = 1'b0;
  logic                   rst, start, s_valid, s_ready, s_sof, s_eol;
  logic [WIDTH_COLOR-1:0] s_data, dout;
  logic [WIDTH_ADDR-1:0]  address;
  logic                   en_write, busy, frame_done, err_line, err_frame;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 pixel_clk = ~pixel_clk;

  image_writer dut (
    .pixel_clk  (pixel_clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_sof      (s_sof),
    .s_eol      (s_eol),
    .address    (address),
    .dout       (dout),
    .en_write   (en_write),
    .busy       (busy),
    .frame_done (frame_done),
    .err_line   (err_line),
    .err_frame  (err_frame)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write is popped against the scoreboard as {frame_done, address, dout}.
  always @(negedge pixel_clk) begin
    logic [W-1:0] e;
    if (en_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, no write expected", address, dout);
      end else begin
        e = exp_q.pop_front();
        check("write{done,addr,data}", {11'd0, frame_done, address, dout}, {11'd0, e});
      end
    end else if (frame_done === 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_done_alone: got frame_done=1 with en_write=0, expected it only with the last write");
    end
  end

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin
      s_data = 4'($urandom_range(0, 15));
      s_sof  = 1'($urandom_range(0, 1));
      s_eol  = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic send(input logic [3:0] d, input logic sof, input logic eol,
                      input logic wr, input int addr, input logic done);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    s_eol   = eol;
    while (s_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (s_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: s_ready=%b after %0d cycles, expected 1", s_ready, n);
    end else begin
      @(posedge pixel_clk);
      if (wr) exp_q.push_back({done, addr[15:0], d});
      #1;
    end
    s_valid = 1'b0;
  endtask

  // One line of len beats at line y; beats past the line width are expected to be dropped.
  task automatic line(input int y, input int len, input logic sof0, input logic with_eol,
                      input logic gaps, input logic last, input logic [3:0] salt);
    for (int x = 0; x < len; x++) begin
      int a;
      logic eol, wr;
      a   = y * WIDTH_IMG + x;
      eol = with_eol && (x == len - 1);
      wr  = (x < WIDTH_IMG);
      if (gaps) idle($urandom_range(0, 1));
      send(a[3:0] ^ salt, sof0 && (x == 0), eol, wr, a, last && eol && wr);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; s_eol = 1'b0;
    repeat (3) tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_address", address, 0);
    check("rst_dout", dout, 0);
    check("rst_en_write", en_write, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_line", err_line, 0);
    check("rst_err_frame", err_frame, 0);
    rst = 1'b0;
    tick();

    // Frame with pre-sof garbage, short line, long line, then a mid-frame sof restart.
    pulse_start();
    check("start_busy", busy, 1);
    check("start_s_ready", s_ready, 1);
    for (int i = 0; i < 5; i++) send(4'hF, 1'b0, (i == 2), 1'b0, 0, 1'b0);
    check("garbage_err_line", err_line, 0);
    line(0, 100, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5);
    check("short_err_line", err_line, 1);
    check("short_err_frame", err_frame, 0);
    pulse_start();
    check("start_ignored_err_line", err_line, 1);
    check("start_ignored_busy", busy, 1);
    line(1, 210, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5);
    for (int y = 2; y < 5; y++) line(y, WIDTH_IMG, 1'b0, 1'b1, 1'b1, 1'b0, 4'h5);
    line(5, 17, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5);
    check("pre_sof_err_frame", err_frame, 0);
    line(0, WIDTH_IMG, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3);
    check("mid_sof_err_frame", err_frame, 1);
    for (int y = 1; y < HEIGHT_IMG; y++)
      line(y, WIDTH_IMG, 1'b0, 1'b1, 1'b0, (y == HEIGHT_IMG - 1), 4'h3);
    repeat (3) tick();
    check("frame1_busy", busy, 0);
    check("frame1_s_ready", s_ready, 0);
    check("frame1_err_line", err_line, 1);
    check("frame1_err_frame", err_frame, 1);

    // Reset in the middle of line 50, together with a start pulse.
    pulse_start();
    check("restart_err_line_clear", err_line, 0);
    check("restart_err_frame_clear", err_frame, 0);
    line(0, 50, 1'b1, 1'b1, 1'b0, 1'b0, 4'h9);
    check("seg_err_line", err_line, 1);
    for (int y = 1; y < 50; y++) line(y, WIDTH_IMG, 1'b0, 1'b1, 1'b0, 1'b0, 4'h9);
    line(50, 7, 1'b0, 1'b0, 1'b0, 1'b0, 4'h9);
    rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("midrst_en_write", en_write, 0);
    check("midrst_busy", busy, 0);
    check("midrst_s_ready", s_ready, 0);
    check("midrst_err_line", err_line, 0);
    check("midrst_err_frame", err_frame, 0);
    check("midrst_address", address, 0);
    rst = 1'b0;
    tick();
    check("rst_beats_start_busy", busy, 0);

    // Clean full frame after reset, with valid gaps on the first lines.
    pulse_start();
    for (int y = 0; y < HEIGHT_IMG; y++)
      line(y, WIDTH_IMG, (y == 0), 1'b1, (y < 2), (y == HEIGHT_IMG - 1), 4'h0);
    repeat (3) tick();
    check("frame2_busy", busy, 0);
    check("frame2_err_line", err_line, 0);
    check("frame2_err_frame", err_frame, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1500000;
    n_err++;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion earlier", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/image_writer.md
Name: image_writer

Overview:
- Capture side of the 200x200 4-bit grayscale frame buffer.
- Takes a pixel stream with valid/ready handshake and start-of-frame/end-of-line markers, and generates raster-order write address, data and write enable for the buffer's write port.
- The VGA readout path reads the other port of the same buffer.
- Captures exactly one frame per start request, checks line/frame framing, and reports completion and errors.

Parameters:
- WIDTH_ADDR, 16, frame-buffer address width (40000 locations)
- WIDTH_COLOR, 4, grayscale pixel width
- WIDTH_POS, 10, x/y counter width
- WIDTH_IMG, 200, pixels per line
- HEIGHT_IMG, 200, lines per frame

Ports:
- pixel_clk  in  1  single clock for all logic
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; arms capture of one frame
- s_valid  in  1  stream beat valid
- s_ready  out  1  stream beat accept
- s_data  in  WIDTH_COLOR  pixel value
- s_sof  in  1  beat is first pixel of frame
- s_eol  in  1  beat is last pixel of line
- address  out  WIDTH_ADDR  buffer write address
- dout  out  WIDTH_COLOR  buffer write data
- en_write  out  1  buffer write enable
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse, frame complete
- err_line  out  1  sticky: line length != WIDTH_IMG seen
- err_frame  out  1  sticky: s_sof seen mid-frame

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE. All outputs 0: s_ready, address, dout, en_write, busy, frame_done, err_line, err_frame. x=0, y=0, row_base=0.
- Reset mid-frame: same as above. en_write is 0 from the next edge. Partially written buffer contents are left as-is.
- Beat accepted iff s_valid & s_ready. s_data, s_sof and s_eol are sampled only on accepted beats.
- s_ready=1 in WAIT_SOF and WRITE; 0 in IDLE and DONE.
- Write latency: address, dout and en_write are registered and appear 1 cycle after the accepted beat. en_write is high for exactly one cycle per written pixel.
- Address = row_base + x.
  - row_base is accumulated by +WIDTH_IMG per line; no multiplier.
  - Maximum address 39999.
- IDLE:
  - start=1 -> WAIT_SOF.
  - On that transition: clear err_line and err_frame; x=0, y=0, row_base=0.
  - start in any other state is ignored.
- WAIT_SOF:
  - Accepted beats with s_sof=0 are dropped (no write).
  - Accepted beat with s_sof=1 -> write at address 0, x=1, -> WRITE.
  - s_sof=1 together with s_eol=1 is handled as an eol at x=0, per the WRITE rules.
- WRITE, per accepted beat:
  - s_sof=1: set err_frame; restart the frame. Write at address 0, x=1, y=0, row_base=0.
  - Else, if x<WIDTH_IMG: write at row_base+x, then x++. x saturates at WIDTH_IMG.
  - Else (x==WIDTH_IMG, overlong line): drop the beat, no write.
  - s_eol=1:
    - If the pixel index of this beat != WIDTH_IMG-1, set err_line. This covers short and long lines.
    - Short line: the unwritten tail keeps its old buffer content.
    - Then x=0, y++, row_base+=WIDTH_IMG.
  - s_eol=1 when y==HEIGHT_IMG-1 -> DONE. That beat is written if in range.
- DONE: one cycle. frame_done=1 in this cycle, coinciding with en_write of the final pixel. -> IDLE.
- busy is registered and follows the state: 1 from the cycle after start through DONE.
- Simultaneous rst and start: rst wins.

Decomposition:
- Shared package/header image_params: WIDTH_IMG, HEIGHT_IMG, WIDTH_ADDR, WIDTH_COLOR, WIDTH_POS.
  - These are shared with the VGA readout path so both agree on buffer geometry.
- State encoding constants (IDLE, WAIT_SOF, WRITE, DONE) are local to this block.
- One sub-module: img_addr_gen.
  - Holds x, y and row_base.
  - Controls: clear, advance-pixel, advance-line.
  - Outputs: address, x_last, line_last.

Test Plan:
- Full frame:
  - Stimulus: rst, start, then 40000 beats with s_data=i[3:0], sof on beat 0, eol every 200th beat.
  - Expect: writes to addresses 0..39999 in order with dout=addr[3:0]; frame_done for exactly 1 cycle, same cycle as the last en_write; both error flags 0; busy=0 afterwards.
- Pre-sof garbage: 5 beats with sof=0 after start -> no en_write; first write at address 0 on the sof beat.
- Short line: line 0 gets eol at pixel 99 -> err_line=1; next beat writes address 200; frame still completes after 200 eols.
- Long line: line 0 has 210 beats, eol on the last -> writes 0..199 only; err_line=1; next beat writes address 200.
- Mid-frame sof: sof at y=5, x=17 -> err_frame=1; write at address 0; the following 40000-beat frame completes normally.
- Gaps and reset:
  - Random s_valid gaps -> addresses stay contiguous.
  - rst at y=50 -> next cycle en_write=0, busy=0, s_ready=0, errors 0.
  - A new start followed by a full frame works.
